// File: rtl/uart_tx_mmio_pkg.sv
// Shared register map, status/control bit positions and TX FSM encoding
// for the memory-mapped UART transmitter.
package uart_tx_mmio_pkg;

    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_CTRL   = 2'd2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_OVF_CLR = 1;

    localparam int FRAME_DATA_BITS = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Generic single-clock FIFO with registered count/full/empty and
// combinational head data; overflowing pushes and underflowing pops are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO and serialiser.
//   state   | meaning
//   S_IDLE  | line high; pop next byte when enabled and FIFO non-empty
//   S_START | start bit (low) for CLKS_PER_BIT cycles
//   S_DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
//   S_STOP  | stop bit (high) for CLKS_PER_BIT cycles
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_sig,
    input  logic [31:0] wr_data,
    input  logic [31:0] addr,
    output logic [31:0] rd_data,
    output logic        tx
);
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_e state, state_n;
    logic [BW-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic          tx_n;
    logic          enable;
    logic          overflow;

    logic          sel;
    logic [1:0]    idx;
    logic          push_req;
    logic          ctrl_wr;
    logic          pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          baud_last;
    logic          unused_bits;

    assign sel       = (addr[31:4] == BASE_ADDR[31:4]);
    assign idx       = addr[3:2];
    assign push_req  = wr_sig & sel & (idx == UART_TXDATA);
    assign ctrl_wr   = wr_sig & sel & (idx == UART_CTRL);
    assign baud_last = (baud_cnt == BAUD_LAST);
    assign unused_bits = &{1'b0, wr_data[31:8], addr[1:0]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_req),
        .pop     (pop),
        .din     (wr_data[7:0]),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && !fifo_empty) begin
                    pop        = 1'b1;
                    shift_n    = fifo_dout;
                    baud_cnt_n = '0;
                    bit_cnt_n  = '0;
                    state_n    = S_START;
                end
            end
            S_START: begin
                baud_cnt_n = baud_last ? '0 : baud_cnt + 1'b1;
                if (baud_last) state_n = S_DATA;
            end
            S_DATA: begin
                baud_cnt_n = baud_last ? '0 : baud_cnt + 1'b1;
                if (baud_last) begin
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_cnt == 3'(FRAME_DATA_BITS - 1)) begin
                        bit_cnt_n = '0;
                        state_n   = S_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            S_STOP: begin
                baud_cnt_n = baud_last ? '0 : baud_cnt + 1'b1;
                if (baud_last) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Line level is derived from the next state so the tx flop tracks the FSM exactly.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            S_START: tx_n = 1'b0;
            S_DATA:  tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
            tx       <= tx_n;
        end
    end

    // A push against a full FIFO sets overflow even if a clear arrives the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable   <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (ctrl_wr) enable <= wr_data[CTRL_EN];
            if (push_req && fifo_full)
                overflow <= 1'b1;
            else if (ctrl_wr && wr_data[CTRL_OVF_CLR])
                overflow <= 1'b0;
        end
    end

    always_comb begin
        rd_data = '0;
        if (sel) begin
            case (idx)
                UART_STATUS: begin
                    rd_data[STAT_BUSY]           = (state != S_IDLE);
                    rd_data[STAT_FULL]           = fifo_full;
                    rd_data[STAT_EMPTY]          = fifo_empty;
                    rd_data[STAT_OVF]            = overflow;
                    rd_data[STAT_CNT_LSB +: 4]   = 4'(fifo_count);
                end
                UART_CTRL: rd_data[CTRL_EN] = enable;
                default:   rd_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: frame-level reference model compared every
// cycle, plus hand-computed register and waveform expectations.
module tb_uart_tx_mmio;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam logic [31:0] A_TX   = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_CTRL = BASE + 32'h8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        wr_sig = 1'b0;
    logic [31:0] wr_data = '0;
    logic [31:0] addr = A_STAT;
    logic [31:0] rd_data;
    logic        tx;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    uart_tx_mmio #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_sig  (wr_sig),
        .wr_data (wr_data),
        .addr    (addr),
        .rd_data (rd_data),
        .tx      (tx)
    );

    always #5 clk = ~clk;

    // Reference model: a byte queue plus "frame active / cycles elapsed in frame".
    logic [7:0] m_q [$];
    bit         m_act = 1'b0;
    int         m_el = 0;
    logic [7:0] m_byte = '0;
    bit         m_en = 1'b1;
    bit         m_ovf = 1'b0;
    int         m_sz_pre;
    bit         m_en_pre;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_act = 1'b0;
            m_el  = 0;
            m_en  = 1'b1;
            m_ovf = 1'b0;
        end else begin
            m_sz_pre = m_q.size();
            m_en_pre = m_en;
            if (m_act) begin
                m_el++;
                if (m_el == 10 * CPB) m_act = 1'b0;
            end else if (m_en_pre && m_sz_pre > 0) begin
                m_byte = m_q.pop_front();
                m_act  = 1'b1;
                m_el   = 0;
            end
            if (wr_sig && addr[31:4] == BASE[31:4]) begin
                if (addr[3:2] == 2'd0) begin
                    if (m_sz_pre >= DEPTH) m_ovf = 1'b1;
                    else m_q.push_back(wr_data[7:0]);
                end else if (addr[3:2] == 2'd2) begin
                    m_en = wr_data[0];
                    if (wr_data[1]) m_ovf = 1'b0;
                end
            end
        end
    end

    function automatic logic m_tx();
        int k;
        if (!m_act) return 1'b1;
        k = m_el / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[k-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_rd(input logic [31:0] a);
        logic [31:0] r;
        r = '0;
        if (a[31:4] != BASE[31:4]) return r;
        if (a[3:2] == 2'd1) begin
            r[0]   = m_act;
            r[1]   = (m_q.size() == DEPTH);
            r[2]   = (m_q.size() == 0);
            r[3]   = m_ovf;
            r[7:4] = 4'(m_q.size());
        end else if (a[3:2] == 2'd2) begin
            r[0] = m_en;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_tx", {31'd0, tx}, {31'd0, m_tx()});
            chk("model_rd", rd_data, m_rd(addr));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wr_data = d; wr_sig = 1'b1;
        tick(1);
        wr_sig = 1'b0; addr = A_STAT;
    endtask

    task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(name, rd_data, exp);
    endtask

    logic frame55 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        #2 reset_n = 1'b0;
        chk_en = 1'b1;
        tick(3);
        reset_n = 1'b1;
        tick(1);
        chk("reset_tx", {31'd0, tx}, 32'd1);
        peek("reset_status", A_STAT, 32'h0000_0004);
        peek("reset_ctrl", A_CTRL, 32'h0000_0001);
        addr = A_STAT;
        tick(2);

        // Single byte 0x55: sample the middle-ish of each bit period.
        wr(A_TX, 32'h55);
        tick(2);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("frame55_bit%0d", i), {31'd0, tx}, {31'd0, frame55[i]});
            if (i == 4) peek("busy_mid_frame", A_STAT, 32'h0000_0005);
            tick(4);
        end
        peek("idle_after_frame", A_STAT, 32'h0000_0004);

        // Overflow: six back-to-back pushes.
        addr = A_TX; wr_sig = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            wr_data = 32'(i);
            tick(1);
        end
        wr_sig = 1'b0; addr = A_STAT;
        peek("overflow_status", A_STAT, 32'h0000_004B);
        tick(5 * 41 + 10);
        peek("drained_status", A_STAT, 32'h0000_000C);
        wr(A_CTRL, 32'h2);
        peek("ctrl_after_clear", A_CTRL, 32'h0000_0000);
        peek("ovf_cleared", A_STAT, 32'h0000_0004);

        // Enable gating.
        wr(A_CTRL, 32'h0);
        wr(A_TX, 32'hA5);
        tick(20);
        chk("gated_tx", {31'd0, tx}, 32'd1);
        peek("gated_status", A_STAT, 32'h0000_0010);
        wr(A_CTRL, 32'h1);
        chk("enable_edge_tx", {31'd0, tx}, 32'd1);
        tick(1);
        chk("enable_start_bit", {31'd0, tx}, 32'd0);
        tick(45);
        peek("after_gated_frame", A_STAT, 32'h0000_0004);

        // Out-of-window write.
        wr(BASE + 32'h10, 32'hFF);
        peek("outside_rd", BASE + 32'h10, 32'h0000_0000);
        peek("outside_no_push", A_STAT, 32'h0000_0004);
        tick(3);
        chk("outside_tx", {31'd0, tx}, 32'd1);

        // Reset during DATA bit 3 of 0xC3 (bit 3 is 0).
        wr(A_TX, 32'hC3);
        tick(17);
        chk("pre_reset_bit3", {31'd0, tx}, 32'd0);
        reset_n = 1'b0;
        #1;
        chk("reset_tx_immediate", {31'd0, tx}, 32'd1);
        peek("reset_mid_status", A_STAT, 32'h0000_0004);
        tick(2);
        reset_n = 1'b1;
        tick(50);
        chk("no_resumed_frame", {31'd0, tx}, 32'd1);
        peek("final_status", A_STAT, 32'h0000_0004);
        peek("final_ctrl", A_CTRL, 32'h0000_0001);
        tick(2);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
